// File: rtl/fir_out_decimator.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_decimator
// Description : Decimates the FIR full-precision output stream, requantizes
//               kept samples with round-half-up and saturation, and buffers
//               them in a show-ahead FIFO drained by valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_out_decimator #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 10,
    parameter int SHIFT = 9,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             drop,
    output logic             sat
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(DEPTH);

    localparam logic [PW-1:0]        C_PH_LAST = PW'(DECIM - 1);
    localparam logic signed [IN_W:0] C_RND     = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] C_MAX     = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] C_MIN     = ~C_MAX;

    logic [PW-1:0]        phase_q, phase_d;
    logic                 s1_v_q, s1_v_d;
    logic signed [IN_W:0] r_q, r_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic                 sat_q, sat_d;
    logic                 drop_q, drop_d;
    logic [OUT_W-1:0]     mem_q [DEPTH];

    logic                 w_keep;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_over;
    logic                 w_under;
    logic signed [IN_W:0] w_sum;
    logic [OUT_W-1:0]     w_res;

    assign w_keep  = in_valid && (phase_q == '0);
    // One extra bit of headroom means the rounding add can never overflow.
    assign w_sum   = $signed({in[IN_W-1], in}) + C_RND;

    assign w_over  = (r_q > C_MAX);
    assign w_under = (r_q < C_MIN);
    assign w_res   = w_over  ? {1'b0, {(OUT_W-1){1'b1}}} :
                     w_under ? {1'b1, {(OUT_W-1){1'b0}}} :
                               r_q[OUT_W-1:0];

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_pop   = !w_empty && out_ready;
    // When full, the slot being written is the one being popped this cycle.
    assign w_wr    = s1_v_q && (!w_full || w_pop);

    always_comb begin
        phase_d  = phase_q;
        s1_v_d   = w_keep;
        r_d      = r_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sat_d    = sat_q;
        drop_d   = s1_v_q && w_full && !w_pop;

        if (in_valid) begin
            phase_d = (phase_q == C_PH_LAST) ? '0 : phase_q + PW'(1);
        end
        if (w_keep) begin
            r_d = w_sum >>> SHIFT;
        end
        if (s1_v_q && (w_over || w_under)) begin
            sat_d = 1'b1;
        end
        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            s1_v_q   <= 1'b0;
            r_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sat_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            s1_v_q   <= s1_v_d;
            r_q      <= r_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sat_q    <= sat_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= w_res;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign drop      = drop_q;
    assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_out_decimator
// Description : Self-checking bench for fir_out_decimator against a
//               queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_out_decimator;
    localparam int IN_W  = 24;
    localparam int OUT_W = 10;
    localparam int SHIFT = 9;
    localparam int DECIM = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [IN_W-1:0]  in_s = '0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             drop;
    logic             sat;

    fir_out_decimator #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT),
        .DECIM(DECIM),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_s),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .drop     (drop),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_err = 0;
    int     m_q[$];
    int     dut_pop[$];
    int     vcnt = 0;
    bit     pend_v = 1'b0;
    longint pend_x = 0;
    bit     m_sat = 1'b0;
    bit     m_drop = 1'b0;

    function automatic longint round_shift(longint x);
        longint num = x + (longint'(1) << (SHIFT - 1));
        longint d   = longint'(1) << SHIFT;
        longint r   = num / d;
        if ((num % d != 0) && (num < 0)) r = r - 1;
        return r;
    endfunction

    // Cycle-level reference: pop, then push the pending kept sample if room.
    function automatic void model_edge();
        longint r;
        int     v;
        if (!rst_n) begin
            m_q.delete();
            vcnt = 0; pend_v = 1'b0; m_sat = 1'b0; m_drop = 1'b0;
            return;
        end
        if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
        m_drop = 1'b0;
        if (pend_v) begin
            r = round_shift(pend_x);
            if (r > 511)       begin v = 511;  m_sat = 1'b1; end
            else if (r < -512) begin v = -512; m_sat = 1'b1; end
            else               v = int'(r);
            if (m_q.size() < DEPTH) m_q.push_back(v);
            else                    m_drop = 1'b1;
        end
        pend_v = in_valid && (vcnt % DECIM == 0);
        pend_x = longint'($signed(in_s));
        if (in_valid) vcnt++;
    endfunction

    function automatic logic [OUT_W-1:0] exp_data();
        return (m_q.size() > 0) ? OUT_W'(m_q[0]) : '0;
    endfunction

    task automatic step();
        #2;
        if (out_valid && out_ready) dut_pop.push_back(int'($signed(out_data)));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        dut_pop.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_s = IN_W'($urandom);
            step();
            n_vec++; if ({out_valid, out_data, drop, sat} !== '0) begin n_err++;
                $display("FAIL reset_outs: got v=%0b d=%0d drop=%0b sat=%0b want all 0", out_valid, out_data, drop, sat); end
        end
        rst_n = 1'b1;
        dut_pop.delete();
        in_s = IN_W'(7 * 512); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_vec++; if (out_valid !== 1'b1 || out_data !== OUT_W'(7)) begin n_err++;
            $display("FAIL first_kept: got v=%0b d=%0d want v=1 d=7", out_valid, out_data); end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL first_pop: got v=%0b want 0", out_valid); end
    endtask

    task automatic test_decimation();
        int first_i = -1;
        do_reset();
        in_s = IN_W'(51200); in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (first_i < 0 && out_valid) first_i = i;
            n_vec++; if (out_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL dec_valid: got %0b want %0b", out_valid, m_q.size() > 0); end
            n_vec++; if (out_data !== exp_data()) begin n_err++; $display("FAIL dec_data: got %0d want %0d", out_data, exp_data()); end
            n_vec++; if (sat !== 1'b0 || drop !== 1'b0) begin n_err++; $display("FAIL dec_flags: got sat=%0b drop=%0b want 0 0", sat, drop); end
        end
        n_vec++; if (first_i != 2) begin n_err++; $display("FAIL dec_latency: got %0d want 2", first_i); end
        n_vec++; if (dut_pop.size() != 7) begin n_err++; $display("FAIL dec_count: got %0d want 7", dut_pop.size()); end
        foreach (dut_pop[i]) begin
            n_vec++; if (dut_pop[i] != 100) begin n_err++; $display("FAIL dec_value[%0d]: got %0d want 100", i, dut_pop[i]); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_rounding();
        int vals[5] = '{256, 255, -256, -257, 767};
        int want[5] = '{1, 0, 0, -1, 1};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < DECIM; j++) begin
                in_s = (j == 0) ? IN_W'(vals[k]) : IN_W'($urandom);
                in_valid = 1'b1;
                step();
                n_vec++; if (out_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL rnd_valid: got %0b want %0b", out_valid, m_q.size() > 0); end
                n_vec++; if (out_data !== exp_data()) begin n_err++; $display("FAIL rnd_data: got %0d want %0d", out_data, exp_data()); end
            end
        end
        in_valid = 1'b0;
        repeat (3) step();
        n_vec++; if (dut_pop.size() != 5) begin n_err++; $display("FAIL rnd_count: got %0d want 5", dut_pop.size()); end
        for (int k = 0; k < 5 && k < dut_pop.size(); k++) begin
            n_vec++; if (dut_pop[k] != want[k]) begin n_err++; $display("FAIL rnd_value[%0d]: got %0d want %0d", k, dut_pop[k], want[k]); end
        end
    endtask

    task automatic test_saturation();
        int vals[3] = '{8388607, -8388608, 0};
        int want[3] = '{511, -512, 0};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < DECIM; j++) begin
                in_s = (j == 0) ? IN_W'(vals[k]) : IN_W'($urandom);
                in_valid = 1'b1;
                step();
                n_vec++; if (out_data !== exp_data()) begin n_err++; $display("FAIL sat_data: got %0d want %0d", out_data, exp_data()); end
                n_vec++; if (sat !== m_sat) begin n_err++; $display("FAIL sat_flag: got %0b want %0b", sat, m_sat); end
            end
        end
        in_valid = 1'b0;
        repeat (3) step();
        n_vec++; if (sat !== 1'b1) begin n_err++; $display("FAIL sat_sticky: got %0b want 1", sat); end
        n_vec++; if (dut_pop.size() != 3) begin n_err++; $display("FAIL sat_count: got %0d want 3", dut_pop.size()); end
        for (int k = 0; k < 3 && k < dut_pop.size(); k++) begin
            n_vec++; if (dut_pop[k] != want[k]) begin n_err++; $display("FAIL sat_value[%0d]: got %0d want %0d", k, dut_pop[k], want[k]); end
        end
    endtask

    task automatic test_backpressure();
        int drops = 0;
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            for (int j = 0; j < DECIM; j++) begin
                in_s = (j == 0) ? IN_W'(k * 512) : IN_W'($urandom);
                in_valid = 1'b1;
                step();
                if (drop) drops++;
                n_vec++; if (drop !== m_drop) begin n_err++; $display("FAIL bp_drop: got %0b want %0b", drop, m_drop); end
                n_vec++; if (out_data !== exp_data()) begin n_err++; $display("FAIL bp_data: got %0d want %0d", out_data, exp_data()); end
            end
        end
        in_valid = 1'b0;
        repeat (2) begin step(); if (drop) drops++; end
        n_vec++; if (drops != 1) begin n_err++; $display("FAIL bp_drop_count: got %0d want 1", drops); end
        out_ready = 1'b1;
        repeat (4) step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got v=%0b want 0", out_valid); end
        n_vec++; if (dut_pop.size() != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", dut_pop.size()); end
        for (int k = 0; k < 4 && k < dut_pop.size(); k++) begin
            n_vec++; if (dut_pop[k] != k + 1) begin n_err++; $display("FAIL bp_value[%0d]: got %0d want %0d", k, dut_pop[k], k + 1); end
        end
    endtask

    task automatic test_full_pop();
        int drops = 0;
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < DECIM; j++) begin
                in_s = (j == 0) ? IN_W'(k * 512) : IN_W'($urandom);
                in_valid = 1'b1;
                step();
            end
        end
        in_s = IN_W'(5 * 512); in_valid = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (2) begin
            step();
            if (drop) drops++;
            n_vec++; if (out_data !== exp_data()) begin n_err++; $display("FAIL fp_data: got %0d want %0d", out_data, exp_data()); end
        end
        n_vec++; if (drops != 0) begin n_err++; $display("FAIL fp_no_drop: got %0d drops want 0", drops); end
        out_ready = 1'b1;
        repeat (2) step();
        out_ready = 1'b0;
        n_vec++; if (dut_pop.size() != 3 || dut_pop[0] != 1 || dut_pop[1] != 2 || dut_pop[2] != 3) begin n_err++;
            $display("FAIL fp_order: got %p want '{1,2,3}", dut_pop); end
        n_vec++; if (out_valid !== 1'b1 || out_data !== OUT_W'(4)) begin n_err++;
            $display("FAIL fp_buffered: got v=%0b d=%0d want v=1 d=4", out_valid, out_data); end
        rst_n = 1'b0;
        #1;
        n_vec++; if ({out_valid, out_data, drop, sat} !== '0) begin n_err++;
            $display("FAIL fp_async_reset: got v=%0b d=%0d drop=%0b sat=%0b want all 0", out_valid, out_data, drop, sat); end
        step();
        rst_n = 1'b1;
        dut_pop.delete();
        in_s = IN_W'(9 * 512); in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        n_vec++; if (dut_pop.size() != 1 || dut_pop[0] != 9) begin n_err++;
            $display("FAIL fp_after_reset: got %p want '{9}", dut_pop); end
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 400; i++) begin
            v = int'($urandom_range(0, 600000)) - 300000;
            in_s      = ($urandom_range(0, 3) == 0) ? IN_W'($urandom) : IN_W'(v);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
            n_vec++; if (out_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL rand_valid: got %0b want %0b", out_valid, m_q.size() > 0); end
            n_vec++; if (out_data !== exp_data()) begin n_err++; $display("FAIL rand_data: got %0d want %0d", out_data, exp_data()); end
            n_vec++; if (drop !== m_drop) begin n_err++; $display("FAIL rand_drop: got %0b want %0b", drop, m_drop); end
            n_vec++; if (sat !== m_sat) begin n_err++; $display("FAIL rand_sat: got %0b want %0b", sat, m_sat); end
        end
    endtask

    initial begin
        test_reset();
        test_decimation();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_full_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_out_decimator.md
# fir_out_decimator

Downstream consumer of the FIR filter's 24-bit full-precision output stream. It decimates the stream by a fixed factor, requantizes each kept sample to the 10-bit input sample format with round-half-up and saturation, and buffers the results in a small FIFO. The FIFO is drained by a valid/ready handshake. It sits between the filter output register and any 10-bit sample sink.

## Interface
- `IN_W`, 24: width of the signed input sample.
- `OUT_W`, 10: width of the signed output sample.
- `SHIFT`, 9: arithmetic right-shift applied during requantization. Must satisfy 1 ≤ SHIFT < IN_W.
- `DECIM`, 4: decimation factor. One of every DECIM valid inputs is kept. Must be ≥ 1.
- `DEPTH`, 4: FIFO depth in entries. Must be a power of two, ≥ 2.

- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in`, in, IN_W: signed sample from the FIR output register.
- `in_valid`, in, 1: `in` holds a new sample this cycle. Tie high for continuous streaming.
- `out_data`, out, OUT_W: signed requantized sample at the FIFO head. Reads 0 whenever `out_valid` = 0.
- `out_valid`, out, 1: FIFO is non-empty.
- `out_ready`, in, 1: sink accepts `out_data`. A pop occurs when `out_valid` & `out_ready`.
- `drop`, out, 1: one-cycle pulse when a kept sample is discarded because the FIFO is full.
- `sat`, out, 1: sticky flag, set when any kept sample saturated. Cleared only by reset.

## Operation
- **Phase counter** (range 0..DECIM-1):
  - Advances on every `in_valid` and wraps from DECIM-1 to 0.
  - Holds when `in_valid` = 0.
  - A sample is kept when `in_valid` = 1 and phase = 0, so the first valid sample after reset is kept.
- **Stage 1** (registered): for a kept sample, computes r = (sign-extended `in` to IN_W+1 bits + 2^(SHIFT-1)) >>> SHIFT. The add cannot overflow. The stage registers r and a stage-valid bit `s1_v`.
- **Stage 2** (combinational into FIFO write):
  - If r > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1 (511) and `sat` is set.
  - If r < -2^(OUT_W-1), the result is -2^(OUT_W-1) (-512) and `sat` is set.
  - Otherwise the result is r truncated to OUT_W bits.
- **FIFO write** happens when `s1_v` = 1 and the FIFO is not full.
  - Write while full with no pop in the same cycle: the sample is discarded and `drop` pulses on the next cycle. FIFO contents are unchanged.
  - Write while full with a pop in the same cycle: the write is accepted and the count is unchanged.
  - Write and pop in the same cycle while not full and not empty: both proceed and the count is unchanged.
- **FIFO read**: show-ahead. `out_data` always shows the head entry while non-empty. A pop advances the read pointer. `out_ready` has no effect while empty.
- **Pointers**: log2(DEPTH)+1 bits each. Full/empty are decided from MSB and index comparison, so there is no separate counter.
- **Reset** (asynchronous, takes effect immediately, including mid-stream):
  - Clears phase, `s1_v`, both pointers, `sat` and `drop`.
  - Buffered data is lost.
  - `out_valid`, `out_data`, `drop` and `sat` all read 0 while `rst_n` = 0.

## Timing
- Reset values: `out_data` = 0, `out_valid` = 0, `drop` = 0, `sat` = 0.
- Latency: a kept sample sampled at edge E0 is written at edge E1. `out_valid` rises after E1. With an empty FIFO and `out_ready` = 1 it is popped at E2.
- `sat` rises after the write edge E1. It is set even if that same sample is dropped.
- `drop` is high for exactly the cycle after the discarding edge.
- Throughput: one input per cycle and one output per cycle. No bubbles are inserted by the block.
- `out_valid` and `out_data` are independent of `out_ready` in the same cycle: there is no combinational path from `out_ready` to outputs.

## Test plan
1. **Reset:** hold `rst_n` = 0 with `in` toggling and `in_valid` = 1 → all outputs 0. After release, the first valid `in` is kept.
2. **Decimation:** `in` = 51200 constant, `in_valid` = 1, `out_ready` = 1 → `out_data` = 100.
   - First `out_valid` appears 2 edges after the first sample.
   - One output follows every 4 cycles.
   - `sat` stays 0.
3. **Rounding:** kept samples 256, 255, -256, -257, 767 → outputs 1, 0, 0, -1, 1, in order.
4. **Saturation:** kept samples 8388607 then -8388608 → outputs 511 then -512, and `sat` = 1. A later kept sample of 0 gives out 0 while `sat` stays 1.
5. **Backpressure:** `out_ready` = 0 while 5 kept samples of values 1..5 arrive (`in` = k·512) →
   - the FIFO holds 1..4;
   - one `drop` pulse occurs after the 5th;
   - then `out_ready` = 1 yields 1, 2, 3, 4 on consecutive cycles, followed by `out_valid` = 0.
6. **Full with pop, then reset mid-stream:**
   - With the FIFO full and `out_ready` = 1 on the write edge → no `drop`, and ordering is preserved.
   - Then assert `rst_n` = 0 with 2 entries buffered → `out_valid` = 0 immediately.
   - After release, the next valid sample is kept and produces the first output.
